// File: rtl/game_pkg.sv
// Shared codes for the snake game controller and datapath: directions and FSM states.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_UP    = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAYING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_OVER    = 3'd3,
    ST_WON     = 3'd4
  } state_t;

endpackage

// File: rtl/game_controller_if.sv
// Controller <-> datapath/board signal bundle; master is the controller side.
interface game_controller_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_start;
  logic       game_over;
  logic       game_won;
  logic [7:0] tail_count;
  logic [1:0] direction;
  logic       step;
  logic       game_rst;
  logic [2:0] state;

  // No valid/ready handshake here: step and game_rst are single-cycle strobes,
  // and direction is guaranteed stable in the cycle step is high.
  modport master (
    input  btn_up, btn_down, btn_left, btn_right, btn_start,
    input  game_over, game_won, tail_count,
    output direction, step, game_rst, state
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, btn_start,
    output game_over, game_won, tail_count,
    input  direction, step, game_rst, state
  );
endinterface

// File: rtl/tick_gen.sv
// Move-rate counter: emits a combinational tick and a registered one-cycle step.
// GAME_CTRL_SPEEDUP_EN shortens the period as the tail grows.
module tick_gen #(
  parameter int unsigned BASE_PERIOD = 6_250_000,
  parameter int unsigned MIN_PERIOD  = 1_250_000,
  parameter int unsigned SPEED_STEP  = 39_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] tail_count,
  output logic       tick,
  output logic       step
);

  logic [31:0] cnt;
  logic [31:0] period;

`ifdef GAME_CTRL_SPEEDUP_EN
  logic [31:0] slowdown;
  // Clamp before subtracting so a long tail can never underflow the period.
  always_comb begin
    slowdown = 32'(tail_count) * SPEED_STEP;
    if (slowdown >= BASE_PERIOD - MIN_PERIOD) period = MIN_PERIOD;
    else                                      period = BASE_PERIOD - slowdown;
  end
`else
  logic unused_tail;
  assign unused_tail = ^tail_count;
  assign period      = BASE_PERIOD;
`endif

  // >= so a period that shrinks below the running count fires immediately.
  assign tick = en && (cnt >= period - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      step <= 1'b0;
    end else begin
      step <= tick;
      if (clr || tick) cnt <= '0;
      else if (en)     cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Snake game controller: run/pause/over FSM, turn arbitration and move pacing.
// Optional macro GAME_CTRL_SPEEDUP_EN enables tail-length speedup in tick_gen.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 6_250_000,
  parameter int unsigned MIN_PERIOD  = 1_250_000,
  parameter int unsigned SPEED_STEP  = 39_000
) (
  input  logic              vga_clk,
  input  logic              rst,
  game_controller_if.master io
);

  state_t state;
  dir_t   committed;
  dir_t   pending;
  dir_t   req;
  logic   req_valid;
  logic   btn_start_q;
  logic   game_rst;
  logic   start_edge;
  logic   run_en;
  logic   clr;
  logic   tick;

  always_comb begin
    req_valid = io.btn_up | io.btn_down | io.btn_left | io.btn_right;
    if      (io.btn_up)   req = DIR_UP;
    else if (io.btn_down) req = DIR_DOWN;
    else if (io.btn_left) req = DIR_LEFT;
    else                  req = DIR_RIGHT;
  end

  assign start_edge = io.btn_start & ~btn_start_q;
  // Counting stops on the cycle the FSM leaves PLAYING, so no step escapes into another state.
  assign run_en = (state == ST_PLAYING) && !io.game_over && !io.game_won && !start_edge;
  assign clr    = (state == ST_IDLE) && start_edge;

  tick_gen #(
    .BASE_PERIOD (BASE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .SPEED_STEP  (SPEED_STEP)
  ) u_tick_gen (
    .clk        (vga_clk),
    .rst        (rst),
    .en         (run_en),
    .clr        (clr),
    .tail_count (io.tail_count),
    .tick       (tick),
    .step       (io.step)
  );

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      committed   <= DIR_RIGHT;
      pending     <= DIR_RIGHT;
      game_rst    <= 1'b0;
      btn_start_q <= 1'b0;
    end else begin
      btn_start_q <= io.btn_start;
      game_rst    <= 1'b0;
      case (state)
        ST_IDLE: if (start_edge) begin
          state     <= ST_PLAYING;
          game_rst  <= 1'b1;
          committed <= DIR_RIGHT;
          pending   <= DIR_RIGHT;
        end
        ST_PLAYING: begin
          if      (io.game_over) state <= ST_OVER;
          else if (io.game_won)  state <= ST_WON;
          else if (start_edge)   state <= ST_PAUSED;
          // Reversal is judged against committed so two fast turns can't fold back.
          if (tick) committed <= pending;
          if (req_valid && (req != dir_t'(~committed))) pending <= req;
        end
        ST_PAUSED: if (start_edge) state <= ST_PLAYING;
        ST_OVER, ST_WON: if (start_edge) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.direction = committed;
  assign io.game_rst  = game_rst;
  assign io.state     = state;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with BASE_PERIOD=8, MIN_PERIOD=4, SPEED_STEP=1.
module tb_game_controller;

  logic vga_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   step_seen;
  logic [7:0] exp_q[$];
  logic [7:0] exp_p;

`ifdef GAME_CTRL_SPEEDUP_EN
  localparam int P2  = 6;
  localparam int P10 = 4;
`else
  localparam int P2  = 8;
  localparam int P10 = 8;
`endif

  game_controller_if io();

  game_controller #(
    .BASE_PERIOD (8),
    .MIN_PERIOD  (4),
    .SPEED_STEP  (1)
  ) dut (
    .vga_clk (vga_clk),
    .rst     (rst),
    .io      (io)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       left;
    logic [2:0] st;
    logic       stp;
    logic       grst;
    logic [1:0] dir;
  } vec_t;

  vec_t vecs[6];

  task automatic cycle();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_step(input int max_cycles, output int cnt);
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (io.step !== 1'b1 && cnt < max_cycles);
    if (io.step !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL step_timeout actual=%0d required=1", io.step);
    end
  endtask

  task automatic chk_period(input string name);
    wait_step(20, n);
    exp_p = exp_q.pop_front();
    chk(name, n, exp_p);
  endtask

  initial begin
    rst = 1'b1;
    io.btn_up = 0; io.btn_down = 0; io.btn_left = 0; io.btn_right = 0;
    io.btn_start = 0; io.game_over = 0; io.game_won = 0; io.tail_count = 8'd0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'b11};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'b11};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 2'b11};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 2'b11};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 2'b11};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 2'b11};

    for (int i = 0; i < 6; i++) begin
      rst          = vecs[i].rst;
      io.btn_start = vecs[i].start;
      io.btn_left  = vecs[i].left;
      cycle();
      chk($sformatf("vec%0d_state", i), io.state, vecs[i].st);
      chk($sformatf("vec%0d_step", i), io.step, vecs[i].stp);
      chk($sformatf("vec%0d_game_rst", i), io.game_rst, vecs[i].grst);
      chk($sformatf("vec%0d_dir", i), io.direction, vecs[i].dir);
    end

    // counter is at 3 here; left held is a reversal of right
    wait_step(20, n);
    chk("first_step_latency", n, 5);
    chk("left_rejected_dir", io.direction, 2'b11);
    wait_step(20, n);
    chk("period_base", n, 8);
    chk("left_rejected_dir2", io.direction, 2'b11);
    cycle();
    chk("step_one_cycle", io.step, 1'b0);

    // up then left inside one period: left only lands a move later
    io.btn_left = 0; io.btn_up = 1;
    cycle();
    io.btn_up = 0; io.btn_left = 1;
    wait_step(20, n);
    chk("turn_up_latency", n, 6);
    chk("turn_up_dir", io.direction, 2'b01);
    wait_step(20, n);
    chk("turn_left_period", n, 8);
    chk("turn_left_dir", io.direction, 2'b00);
    io.btn_left = 0;

    // pause with counter at 5
    repeat (5) cycle();
    io.btn_start = 1;
    cycle();
    chk("pause_state", io.state, 3'd2);
    chk("pause_step", io.step, 1'b0);
    io.btn_start = 0; io.btn_up = 1;
    step_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (io.step) step_seen++;
    end
    chk("pause_no_step", step_seen, 0);
    chk("pause_hold_state", io.state, 3'd2);
    io.btn_up = 0; io.btn_start = 1;
    cycle();
    chk("resume_state", io.state, 3'd1);
    io.btn_start = 0;
    wait_step(20, n);
    chk("resume_latency", n, 3);
    chk("pause_ignored_dir", io.direction, 2'b00);

    // over beats won
    io.game_over = 1; io.game_won = 1;
    cycle();
    chk("over_state", io.state, 3'd3);
    chk("over_step", io.step, 1'b0);
    io.game_over = 0; io.game_won = 0;
    step_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (io.step) step_seen++;
    end
    chk("over_no_step", step_seen, 0);
    io.btn_start = 1;
    cycle();
    chk("ack_idle_state", io.state, 3'd0);
    chk("ack_no_game_rst", io.game_rst, 1'b0);
    io.btn_start = 0;
    cycle();
    chk("idle_stays", io.state, 3'd0);
    chk("idle_no_game_rst", io.game_rst, 1'b0);

    // second game: speed vs tail length
    io.btn_start = 1;
    cycle();
    chk("restart_state", io.state, 3'd1);
    chk("restart_game_rst", io.game_rst, 1'b1);
    io.btn_start = 0;
    exp_q.push_back(8'd8);
    exp_q.push_back(8'(P2));
    exp_q.push_back(8'(P2));
    exp_q.push_back(8'(P10));
    exp_q.push_back(8'(P10));
    chk_period("period_tail0");
    io.tail_count = 8'd2;
    chk_period("period_tail2");
    io.btn_up = 1;
    chk_period("period_tail2b");
    chk("turn_up_game2", io.direction, 2'b01);
    io.btn_up = 0;
    io.tail_count = 8'd10;
    chk_period("period_tail10");
    chk_period("period_tail10b");

    // reset lands with a visible step and a start edge
    rst = 1; io.btn_start = 1;
    cycle();
    chk("rst_state", io.state, 3'd0);
    chk("rst_step", io.step, 1'b0);
    chk("rst_game_rst", io.game_rst, 1'b0);
    chk("rst_dir", io.direction, 2'b11);
    rst = 0; io.btn_start = 0;
    cycle();
    chk("post_rst_state", io.state, 3'd0);
    chk("post_rst_step", io.step, 1'b0);
    chk("post_rst_game_rst", io.game_rst, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
